// File: rtl/system_bus_hs.sv
// system_bus_hs: single-master to NSLV-slave request/ack bus bridge.
// Decodes m_addr against base/mask regions, latches the request onto the
// broadcast s_* bus, waits for the selected slave's ack (bounded by
// TIMEOUT ACCESS cycles) and returns a one-cycle m_rvalid response.
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   m_req/m_addr/m_wdata/m_rd_ctrl/m_wr_ctrl   master request
//   m_ready                             request accepted this cycle
//   m_rvalid/m_rdata/m_err              one-cycle response
//   s_req                               one-hot slave select
//   s_addr/s_wdata/s_rd_ctrl/s_wr_ctrl  latched request, broadcast
//   s_ack/s_rdata                       per-slave completion and data
module system_bus_hs #(
   parameter int NSLV    = 3,
   parameter int AW      = 64,
   parameter int DW      = 64,
   parameter int TIMEOUT = 16,
   parameter logic [NSLV*AW-1:0] SLV_BASE = {
      64'h0000_0000_8000_0000,
      64'h0000_0000_4000_0000,
      64'h0000_0000_0000_0000},
   parameter logic [NSLV*AW-1:0] SLV_MASK = {
      ~64'h0FFF,
      ~64'h000F,
      ~64'h3FFF}
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               m_req,
   input  logic [AW-1:0]      m_addr,
   input  logic [DW-1:0]      m_wdata,
   input  logic [2:0]         m_rd_ctrl,
   input  logic [2:0]         m_wr_ctrl,
   output logic               m_ready,
   output logic               m_rvalid,
   output logic [DW-1:0]      m_rdata,
   output logic               m_err,
   output logic [NSLV-1:0]    s_req,
   output logic [AW-1:0]      s_addr,
   output logic [DW-1:0]      s_wdata,
   output logic [2:0]         s_rd_ctrl,
   output logic [2:0]         s_wr_ctrl,
   input  logic [NSLV-1:0]    s_ack,
   input  logic [NSLV*DW-1:0] s_rdata
);

   localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [2:0]      rd_q, rd_d;
   logic [2:0]      wr_q, wr_d;
   logic [SW-1:0]   sel_q, sel_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [DW-1:0]   rdata_q, rdata_d;

   logic            accept;
   logic            hit;
   logic [SW-1:0]   hit_idx;
   logic            ack_sel;
   logic            tmo;
   logic [DW-1:0]   slot_rdata;

   assign m_ready    = (state_q == IDLE) && rst_n;
   assign accept     = m_req && m_ready;
   assign ack_sel    = s_ack[sel_q];
   assign slot_rdata = s_rdata[DW*int'(sel_q) +: DW];
   // Last permitted ACCESS cycle: counter starts at 0 in cycle 1.
   assign tmo        = (cnt_q == CW'(TIMEOUT - 1));

   // Walk downwards so the lowest matching index is the one kept.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = NSLV - 1; i >= 0; i--) begin
         if ((m_addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
            hit     = 1'b1;
            hit_idx = SW'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               if (!hit || (m_rd_ctrl == 3'd0 && m_wr_ctrl == 3'd0))
                  state_d = ERR;
               else
                  state_d = ACCESS;
            end
         end
         // Ack is checked first so it wins over a same-cycle timeout.
         ACCESS: begin
            if (ack_sel)
               state_d = RESP;
            else if (tmo)
               state_d = ERR;
         end
         RESP:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      m_rvalid = 1'b0;
      m_err    = 1'b0;
      m_rdata  = '0;
      s_req    = '0;
      unique case (state_q)
         IDLE: ;
         ACCESS:  s_req[sel_q] = 1'b1;
         RESP: begin
            m_rvalid = 1'b1;
            m_rdata  = rdata_q;
         end
         ERR: begin
            m_rvalid = 1'b1;
            m_err    = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      if (accept) begin
         addr_d  = m_addr;
         wdata_d = m_wdata;
         rd_d    = m_rd_ctrl;
         wr_d    = m_wr_ctrl;
         sel_d   = hit_idx;
         cnt_d   = '0;
      end
      if (state_q == ACCESS) begin
         cnt_d = cnt_q + CW'(1);
         if (ack_sel)
            rdata_d = (rd_q != 3'd0) ? slot_rdata : '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         wdata_q <= '0;
         rd_q    <= '0;
         wr_q    <= '0;
         sel_q   <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
      end else begin
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
      end
   end

   assign s_addr    = addr_q;
   assign s_wdata   = wdata_q;
   assign s_rd_ctrl = rd_q;
   assign s_wr_ctrl = wr_q;

endmodule

// File: tb/tb_system_bus_hs.sv
// tb_system_bus_hs: directed self-checking bench for system_bus_hs.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_system_bus_hs;

   logic         clk;
   logic         rst_n;
   logic         m_req;
   logic [63:0]  m_addr;
   logic [63:0]  m_wdata;
   logic [2:0]   m_rd_ctrl;
   logic [2:0]   m_wr_ctrl;
   logic         m_ready;
   logic         m_rvalid;
   logic [63:0]  m_rdata;
   logic         m_err;
   logic [2:0]   s_req;
   logic [63:0]  s_addr;
   logic [63:0]  s_wdata;
   logic [2:0]   s_rd_ctrl;
   logic [2:0]   s_wr_ctrl;
   logic [2:0]   s_ack;
   logic [191:0] s_rdata;

   int tests = 0;
   int fails = 0;
   int rsp_cnt = 0;
   int base;

   int          n, lat;
   logic [2:0]  seen;
   logic        err, got;
   logic [63:0] data;

   system_bus_hs dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .m_req     (m_req),
      .m_addr    (m_addr),
      .m_wdata   (m_wdata),
      .m_rd_ctrl (m_rd_ctrl),
      .m_wr_ctrl (m_wr_ctrl),
      .m_ready   (m_ready),
      .m_rvalid  (m_rvalid),
      .m_rdata   (m_rdata),
      .m_err     (m_err),
      .s_req     (s_req),
      .s_addr    (s_addr),
      .s_wdata   (s_wdata),
      .s_rd_ctrl (s_rd_ctrl),
      .s_wr_ctrl (s_wr_ctrl),
      .s_ack     (s_ack),
      .s_rdata   (s_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk)
      if (m_rvalid) rsp_cnt = rsp_cnt + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called on a falling edge with m_ready high; returns one edge later.
   task automatic issue(input logic [63:0] a, input logic [63:0] wd,
                        input logic [2:0] rd, input logic [2:0] wr);
      m_addr    = a;
      m_wdata   = wd;
      m_rd_ctrl = rd;
      m_wr_ctrl = wr;
      m_req     = 1'b1;
      @(negedge clk);
      m_req     = 1'b0;
   endtask

   // Acks on the ack_cyc-th cycle that s_req is seen (0 = never).
   task automatic wait_resp(input int ack_cyc, input int slot,
                            input logic [63:0] rd,
                            output int cnt, output int l,
                            output logic [2:0] sn, output logic e,
                            output logic [63:0] d, output logic g);
      cnt = 0; l = 0; sn = '0; e = 1'b0; d = '0; g = 1'b0;
      for (int i = 0; i < 40; i++) begin
         s_ack = '0;
         if (m_rvalid) begin
            g = 1'b1;
            e = m_err;
            d = m_rdata;
            break;
         end
         if (s_req != 3'd0) cnt++;
         sn = sn | s_req;
         l++;
         if (ack_cyc != 0 && cnt == ack_cyc) begin
            s_ack[slot] = 1'b1;
            s_rdata[slot*64 +: 64] = rd;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      m_req     = 1'b0;
      m_addr    = '0;
      m_wdata   = '0;
      m_rd_ctrl = '0;
      m_wr_ctrl = '0;
      s_ack     = '0;
      s_rdata   = '0;
      repeat (2) @(negedge clk);

      chk("rst_ready",  64'(m_ready),  64'd0);
      chk("rst_sreq",   64'(s_req),    64'd0);
      chk("rst_rvalid", 64'(m_rvalid), 64'd0);
      chk("rst_rdata",  m_rdata,       64'd0);
      chk("rst_saddr",  s_addr,        64'd0);
      chk("rst_rdctl",  64'(s_rd_ctrl), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_ready", 64'(m_ready), 64'd1);

      // Read to slave 2, ack in 3rd ACCESS cycle
      issue(64'h8000_0010, 64'h0, 3'd3, 3'd0);
      chk("rd_saddr", s_addr, 64'h8000_0010);
      chk("rd_rdctl", 64'(s_rd_ctrl), 64'd3);
      chk("rd_busy",  64'(m_ready), 64'd0);
      wait_resp(3, 2, 64'hDEAD_BEEF_0123_4567, n, lat, seen, err, data, got);
      chk("rd_got",   64'(got),  64'd1);
      chk("rd_ncyc",  64'(n),    64'd3);
      chk("rd_sreq",  64'(seen), 64'b100);
      chk("rd_err",   64'(err),  64'd0);
      chk("rd_data",  data,      64'hDEAD_BEEF_0123_4567);
      @(negedge clk);
      chk("rd_after_rv", 64'(m_rvalid), 64'd0);
      chk("rd_after_rd", m_rdata,       64'd0);
      chk("rd_after_ok", 64'(m_ready),  64'd1);

      // Write to slave 1, immediate ack; read data must be zero
      issue(64'h4000_0004, 64'h55, 3'd0, 3'd2);
      chk("wr_wdata", s_wdata, 64'h55);
      chk("wr_wrctl", 64'(s_wr_ctrl), 64'd2);
      chk("wr_sreq0", 64'(s_req), 64'b010);
      wait_resp(1, 1, 64'hABCD, n, lat, seen, err, data, got);
      chk("wr_got",  64'(got), 64'd1);
      chk("wr_ncyc", 64'(n),   64'd1);
      chk("wr_lat",  64'(lat), 64'd1);
      chk("wr_err",  64'(err), 64'd0);
      chk("wr_data", data,     64'd0);
      @(negedge clk);

      // Unmapped address: error in first cycle after accept
      issue(64'h2000_0000, 64'h0, 3'd1, 3'd0);
      chk("um_sreq", 64'(s_req), 64'd0);
      wait_resp(0, 0, 64'h0, n, lat, seen, err, data, got);
      chk("um_got",  64'(got), 64'd1);
      chk("um_lat",  64'(lat), 64'd0);
      chk("um_err",  64'(err), 64'd1);
      chk("um_data", data,     64'd0);
      @(negedge clk);

      // Mapped but no control: error; also back-to-back after ERR
      issue(64'h100, 64'h0, 3'd0, 3'd0);
      wait_resp(0, 0, 64'h0, n, lat, seen, err, data, got);
      chk("nc_got",  64'(got), 64'd1);
      chk("nc_seen", 64'(seen), 64'd0);
      chk("nc_err",  64'(err), 64'd1);
      @(negedge clk);

      // Timeout with no ack
      issue(64'h100, 64'h0, 3'd1, 3'd0);
      wait_resp(0, 0, 64'h0, n, lat, seen, err, data, got);
      chk("to_got",  64'(got),  64'd1);
      chk("to_ncyc", 64'(n),    64'd16);
      chk("to_sreq", 64'(seen), 64'b001);
      chk("to_err",  64'(err),  64'd1);
      chk("to_data", data,      64'd0);
      @(negedge clk);

      // Ack in the final permitted cycle wins over timeout
      issue(64'h100, 64'h0, 3'd1, 3'd0);
      wait_resp(16, 0, 64'h1234, n, lat, seen, err, data, got);
      chk("tl_got",  64'(got), 64'd1);
      chk("tl_ncyc", 64'(n),   64'd16);
      chk("tl_err",  64'(err), 64'd0);
      chk("tl_data", data,     64'h1234);
      @(negedge clk);

      // Reset during ACCESS cycle 2
      base = rsp_cnt;
      issue(64'h100, 64'h0, 3'd1, 3'd0);
      @(negedge clk);
      chk("ra_sreq_pre", 64'(s_req), 64'b001);
      rst_n = 1'b0;
      #1;
      chk("ra_sreq",  64'(s_req),    64'd0);
      chk("ra_ready", 64'(m_ready),  64'd0);
      chk("ra_rv",    64'(m_rvalid), 64'd0);
      chk("ra_saddr", s_addr,        64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("ra_ready1", 64'(m_ready), 64'd1);
      repeat (3) @(negedge clk);
      chk("ra_norsp", 64'(rsp_cnt - base), 64'd0);
      chk("ra_idle",  64'(m_ready),        64'd1);

      // Back to back, m_req held, stray ack from slave 0
      base      = rsp_cnt;
      m_addr    = 64'h8000_0010;
      m_wdata   = 64'h0;
      m_rd_ctrl = 3'd1;
      m_wr_ctrl = 3'd0;
      m_req     = 1'b1;
      @(negedge clk);
      chk("bb_sreqA", 64'(s_req), 64'b100);
      m_addr    = 64'h4000_0008;
      m_wdata   = 64'h77;
      m_rd_ctrl = 3'd0;
      m_wr_ctrl = 3'd1;
      s_ack     = 3'b001;
      @(negedge clk);
      chk("bb_stray_sreq", 64'(s_req),    64'b100);
      chk("bb_stray_rv",   64'(m_rvalid), 64'd0);
      chk("bb_hold_addr",  s_addr,        64'h8000_0010);
      s_ack = 3'b100;
      s_rdata[128 +: 64] = 64'h1111;
      @(negedge clk);
      s_ack = '0;
      chk("bb_rvA",    64'(m_rvalid), 64'd1);
      chk("bb_errA",   64'(m_err),    64'd0);
      chk("bb_dataA",  m_rdata,       64'h1111);
      @(negedge clk);
      chk("bb_idle",   64'(m_ready),  64'd1);
      chk("bb_idlerv", 64'(m_rvalid), 64'd0);
      @(negedge clk);
      m_req = 1'b0;
      chk("bb_sreqB",  64'(s_req), 64'b010);
      chk("bb_addrB",  s_addr,     64'h4000_0008);
      chk("bb_wdataB", s_wdata,    64'h77);
      s_rdata[64 +: 64] = 64'h9999;
      s_ack = 3'b010;
      @(negedge clk);
      s_ack = '0;
      chk("bb_rvB",   64'(m_rvalid), 64'd1);
      chk("bb_dataB", m_rdata,       64'd0);
      repeat (3) @(negedge clk);
      chk("bb_nrsp", 64'(rsp_cnt - base), 64'd2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
